// File: rtl/uart_packet_controller.sv
// rtl/uart_packet_controller.sv - UART byte-stream framer: SYNC, CMD, LEN, payload, 8-bit additive checksum
// Payload bytes are written out as they arrive; o_Pkt_Done/o_Pkt_Err report the frame verdict.
module uart_packet_controller #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 3470,
    parameter int         ADDR_WIDTH   = 8
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Rx_DV,
    input  logic [7:0]            i_Rx_Byte,
    output logic                  o_Wr_En,
    output logic [ADDR_WIDTH-1:0] o_Wr_Addr,
    output logic [7:0]            o_Wr_Data,
    output logic [7:0]            o_Cmd,
    output logic                  o_Pkt_Done,
    output logic                  o_Pkt_Err,
    output logic                  o_Busy,
    output logic [7:0]            o_Err_Count
);

    localparam int TC_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_LEN,
        GET_PAYLOAD,
        GET_CHK
    } state_t;

    state_t          state;
    logic [7:0]      cmd_reg;
    logic [7:0]      len_reg;
    logic [7:0]      sum;
    logic [7:0]      idx;
    logic [TC_W-1:0] tcount;

    assign o_Busy = (state != IDLE);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= IDLE;
            cmd_reg     <= 8'd0;
            len_reg     <= 8'd0;
            sum         <= 8'd0;
            idx         <= 8'd0;
            tcount      <= '0;
            o_Wr_En     <= 1'b0;
            o_Wr_Addr   <= '0;
            o_Wr_Data   <= 8'd0;
            o_Cmd       <= 8'd0;
            o_Pkt_Done  <= 1'b0;
            o_Pkt_Err   <= 1'b0;
            o_Err_Count <= 8'd0;
        end else begin
            o_Wr_En    <= 1'b0;
            o_Pkt_Done <= 1'b0;
            o_Pkt_Err  <= 1'b0;

            if (state == IDLE || i_Rx_DV)
                tcount <= '0;
            else
                tcount <= tcount + TC_W'(1);

            // A received byte always takes priority over an expiring timeout.
            if (i_Rx_DV) begin
                case (state)
                    IDLE: begin
                        if (i_Rx_Byte == SYNC_BYTE)
                            state <= GET_CMD;
                    end
                    GET_CMD: begin
                        cmd_reg <= i_Rx_Byte;
                        sum     <= i_Rx_Byte;
                        state   <= GET_LEN;
                    end
                    GET_LEN: begin
                        len_reg <= i_Rx_Byte;
                        sum     <= sum + i_Rx_Byte;
                        idx     <= 8'd0;
                        state   <= (i_Rx_Byte != 8'd0) ? GET_PAYLOAD : GET_CHK;
                    end
                    GET_PAYLOAD: begin
                        o_Wr_En   <= 1'b1;
                        o_Wr_Data <= i_Rx_Byte;
                        o_Wr_Addr <= ADDR_WIDTH'(idx);
                        sum       <= sum + i_Rx_Byte;
                        idx       <= idx + 8'd1;
                        if (idx == len_reg - 8'd1)
                            state <= GET_CHK;
                    end
                    GET_CHK: begin
                        if (i_Rx_Byte == sum) begin
                            o_Pkt_Done <= 1'b1;
                            o_Cmd      <= cmd_reg;
                        end else begin
                            o_Pkt_Err   <= 1'b1;
                            o_Err_Count <= (o_Err_Count == 8'hFF) ? 8'hFF : o_Err_Count + 8'd1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tcount == TC_LAST) begin
                o_Pkt_Err   <= 1'b1;
                o_Err_Count <= (o_Err_Count == 8'hFF) ? 8'hFF : o_Err_Count + 8'd1;
                state       <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_packet_controller.sv
// tb/tb_uart_packet_controller.sv - scoreboard bench for uart_packet_controller
// Stimulus pushes expected write/done/error events; a negedge monitor pops and compares them.
module tb_uart_packet_controller;

    localparam int TO = 3470;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] cmd;
    logic       pkt_done;
    logic       pkt_err;
    logic       busy;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;

    typedef struct {
        int kind;  // 0 write, 1 done, 2 error
        int a;
        int b;
    } exp_t;

    exp_t q[$];

    uart_packet_controller #(
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CLKS(TO),
        .ADDR_WIDTH(8)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_Rx_DV(rx_dv),
        .i_Rx_Byte(rx_byte),
        .o_Wr_En(wr_en),
        .o_Wr_Addr(wr_addr),
        .o_Wr_Data(wr_data),
        .o_Cmd(cmd),
        .o_Pkt_Done(pkt_done),
        .o_Pkt_Err(pkt_err),
        .o_Busy(busy),
        .o_Err_Count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic exp_write(input int addr, input int data);
        q.push_back('{0, addr, data});
    endtask

    task automatic exp_done(input int c);
        q.push_back('{1, c, 0});
    endtask

    task automatic exp_error();
        exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
        q.push_back('{2, exp_err, 0});
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (pkt_done || pkt_err) begin
                check("pulse_exclusive", {wr_en, pkt_done & pkt_err}, 0);
            end
            if (wr_en) begin
                if (q.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    e = q.pop_front();
                    check("write_kind", 0, e.kind);
                    check("write_addr", wr_addr, e.a);
                    check("write_data", wr_data, e.b);
                end
            end
            if (pkt_done) begin
                if (q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    e = q.pop_front();
                    check("done_kind", 1, e.kind);
                    check("done_cmd", cmd, e.a);
                end
            end
            if (pkt_err) begin
                if (q.size() == 0) check("unexpected_err", 1, 0);
                else begin
                    e = q.pop_front();
                    check("err_kind", 2, e.kind);
                    check("err_count", err_count, e.a);
                end
            end
        end
    end

    initial begin
        #1;
        check("reset_busy", busy, 0);
        check("reset_outputs", {wr_en, pkt_done, pkt_err, cmd, err_count}, 0);
        idle(3);
        rst = 1'b0;
        idle(2);

        // Basic three-byte payload frame
        exp_write(0, 8'h10); exp_write(1, 8'h20); exp_write(2, 8'h30); exp_done(8'h01);
        send(8'hA5); send(8'h01); send(8'h03); send(8'h10); send(8'h20); send(8'h30); send(8'h64);
        idle(2);
        check("cmd_after_frame1", cmd, 8'h01);
        check("errcnt_after_frame1", err_count, 0);

        // Zero-length frame, then same frame with bad checksum
        exp_done(8'h07);
        send(8'hA5); send(8'h07); send(8'h00); send(8'h07);
        exp_error();
        send(8'hA5); send(8'h07); send(8'h00); send(8'h08);
        idle(2);
        check("cmd_kept_on_err", cmd, 8'h07);
        check("errcnt_one", err_count, 1);

        // Leading garbage ignored; SYNC value inside payload is data
        exp_write(0, 8'hA5); exp_done(8'h02);
        send(8'h00); send(8'hFF); send(8'hA5); send(8'h02); send(8'h01); send(8'hA5); send(8'hA8);
        idle(2);
        check("cmd_frame3", cmd, 8'h02);
        check("idle_busy", busy, 0);

        // Byte exactly at the timeout boundary is accepted, then silence aborts
        exp_write(0, 8'h10); exp_write(1, 8'h20);
        send(8'hA5); send(8'h01); send(8'h02); send(8'h10);
        idle(TO - 2);
        send(8'h20);
        check("busy_after_boundary", busy, 1);
        exp_error();
        idle(TO + 5);
        check("busy_after_timeout", busy, 0);
        check("errcnt_after_timeout", err_count, 2);

        // Error counter saturation
        for (int i = 0; i < 256; i++) begin
            exp_error();
            send(8'hA5); send(8'h01); send(8'h00); send(8'h00);
        end
        idle(2);
        check("errcnt_saturated", err_count, 255);

        // Reset mid-payload: outputs clear at once, no error pulse
        exp_write(0, 8'h11);
        send(8'hA5); send(8'h03); send(8'h02); send(8'h11);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_outputs", {wr_en, pkt_done, pkt_err, cmd, err_count}, 0);
        exp_err = 0;
        idle(2);
        rst = 1'b0;
        exp_write(0, 8'h22); exp_done(8'h04);
        send(8'hA5); send(8'h04); send(8'h01); send(8'h22); send(8'h27);
        idle(3);
        check("cmd_after_reset", cmd, 8'h04);
        check("errcnt_after_reset", err_count, 0);
        check("scoreboard_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
